alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32I/RV32M ALU. Base ops and divide special cases finish in one cycle.
// Multiply and divide iterate one bit per cycle. Define ALU_FAST_MUL_EN for a single-cycle multiplier.
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      Data_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [SHW-1:0]  cnt;
  logic [3:0]      op;
  logic [XLEN-1:0] acc;   // product high half / partial remainder
  logic [XLEN-1:0] mq;    // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] opd;   // multiplicand / divisor magnitude
  logic            neg;   // negate the final result

  function automatic logic [XLEN-1:0] base_op(input logic [3:0]      sel,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = b[SHW-1:0];
    case (sel)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Request decode: single-cycle result or operand magnitudes for iteration.
  logic            is_mul, is_div, is_rem, is_signed;
  logic            a_neg, b_neg, neg_in, div_zero, div_ovf, fast_path;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] mul_full;
`endif

  // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
  always_comb begin
    is_mul    = Data_sel[3:1] == 3'b101;
    is_div    = Data_sel[3:2] == 2'b11;
    is_rem    = is_div && Data_sel[1];
    is_signed = is_mul || (is_div && !Data_sel[0]);
    a_neg     = is_signed && A[XLEN-1];
    b_neg     = is_signed && B[XLEN-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    neg_in    = is_rem ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div && (B == '0);
    div_ovf   = is_div && is_signed && (A == MOST_NEG) && (B == '1);
    fast_path = (!is_mul && !is_div) || div_zero || div_ovf;
    fast_res  = base_op(Data_sel, A, B);
    if (div_zero) begin
      fast_res = is_rem ? A : '1;
    end else if (div_ovf) begin
      fast_res = is_rem ? '0 : A;
    end
`ifdef ALU_FAST_MUL_EN
    mul_full = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{B[XLEN-1]}}, B};
    if (is_mul) begin
      fast_path = 1'b1;
      fast_res  = (Data_sel == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration step plus the sign-corrected result of the final step.
  logic              op_mul, take;
  logic [XLEN:0]     add_sum, shifted;
  logic [XLEN-1:0]   acc_nx, mq_nx, quot, rem_v, iter_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    op_mul  = op[3:1] == 3'b101;
    add_sum = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
    shifted = {acc, mq[XLEN-1]};
    take    = shifted >= {1'b0, opd};
    if (op_mul) begin
      acc_nx = add_sum[XLEN:1];
      mq_nx  = {add_sum[0], mq[XLEN-1:1]};
    end else if (take) begin
      acc_nx = shifted[XLEN-1:0] - opd;
      mq_nx  = {mq[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = shifted[XLEN-1:0];
      mq_nx  = {mq[XLEN-2:0], 1'b0};
    end
    prod  = {acc_nx, mq_nx};
    if (neg) prod = -prod;
    quot  = neg ? -mq_nx : mq_nx;
    rem_v = neg ? -acc_nx : acc_nx;
    case (op)
      OP_MUL:          iter_res = prod[XLEN-1:0];
      OP_MULH:         iter_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: iter_res = quot;
      default:         iter_res = rem_v;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_ADD;
      acc   <= '0;
      mq    <= '0;
      opd   <= '0;
      neg   <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op <= Data_sel;
            if (fast_path) begin
              res   <= fast_res;
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= SHW'(XLEN-1);
              acc   <= '0;
              mq    <= is_mul ? b_mag : a_mag;
              opd   <= is_mul ? a_mag : b_mag;
              neg   <= neg_in;
            end
          end
        end
        BUSY: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res   <= iter_res;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against an arithmetic reference model.
// Honours ALU_FAST_MUL_EN for expected multiply latency; XLEN may be set to 8..32.
module tb_alu_muldiv_seq;

  parameter int XLEN = 32;
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES  = '1;
`ifdef ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0, SLT = 4'd3, SRA = 4'd7, MUL = 4'd10, MULH = 4'd11;
  localparam logic [3:0] DIV = 4'd12, DIVU = 4'd13, REM = 4'd14, REMU = 4'd15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] A = '0;
  logic [XLEN-1:0] B = '0;
  logic [3:0]      Data_sel = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] res;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Data_sel  (Data_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; SV division truncates toward zero
  // and the remainder follows the dividend, matching RV32M.
  function automatic logic [XLEN-1:0] ref_model(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub, r;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(ub % longint'(XLEN));
    case (op)
      4'd0:    r = sa + sb;
      4'd1:    r = sa - sb;
      4'd2:    r = ua << sh;
      4'd3:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'd4:    r = (ua < ub) ? 64'd1 : 64'd0;
      4'd5:    r = ua ^ ub;
      4'd6:    r = ua >> sh;
      4'd7:    r = sa >>> sh;
      4'd8:    r = ua | ub;
      4'd9:    r = ua & ub;
      4'd10:   r = sa * sb;
      4'd11:   r = (sa * sb) >>> XLEN;
      4'd12:   r = (sb == 0) ? -64'sd1 : sa / sb;
      4'd13:   r = (ub == 0) ? -64'sd1 : ua / ub;
      4'd14:   r = (sb == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic int ref_latency(input logic [3:0]      op,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (op < 4'd10) return 1;
    if (op >= 4'd12) begin
      if (b == '0) return 1;
      if ((op == DIV || op == REM) && a == MIN_V && b == ONES) return 1;
      return XLEN + 1;
    end
    return FAST_MUL ? 1 : XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return ONES;
      2:       return MIN_V;
      3:       return XLEN'($urandom_range(0, 9));
      default: return XLEN'($urandom);
    endcase
  endfunction

  // Issue one request, wait for its result, apply backpressure, then hand it off.
  // poke drives in_valid during the hand-off edge, which must not be accepted.
  task automatic do_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int hold, input bit early_ready, input bit poke);
    logic [XLEN-1:0] exp_res, held;
    int exp_lat, lat, nbusy, waited;
    exp_res   = ref_model(op, a, b);
    exp_lat   = ref_latency(op, a, b);
    A         = a;
    B         = b;
    Data_sel  = op;
    in_valid  = 1'b1;
    out_ready = early_ready;
    waited    = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready before accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = XLEN'($urandom);
    B        = XLEN'($urandom);
    Data_sel = 4'($urandom);
    lat      = 1;
    nbusy    = 0;
    while (!out_valid && lat < XLEN + 8) begin
      if (busy) nbusy++;
      check("in_ready while iterating", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check($sformatf("busy cycles op%0d", op), nbusy, exp_lat - 1);
    check($sformatf("res op%0d a=%0h b=%0h", op, a, b), res, exp_res);
    check("in_ready in DONE", in_ready, 0);
    held = res;
    if (!early_ready) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("res held", res, held);
        check("out_valid held", out_valid, 1);
        check("in_ready held", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    in_valid = poke;
    @(posedge clk); #1;
    check("out_valid after handoff", out_valid, 0);
    check("in_ready after handoff", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_op();
    A        = XLEN'(100);
    B        = XLEN'(7);
    Data_sel = DIVU;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset res", res, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (XLEN + 4) @(posedge clk);
    #1;
    check("no result after reset", out_valid, 0);
    check("no stale res", res, 0);
    check("idle after reset", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst res", res, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", in_ready, 1);

    do_op(ADD,  XLEN'(2), ONES, 0, 1'b0, 1'b0);
    do_op(SRA,  MIN_V, XLEN'(4), 0, 1'b0, 1'b0);
    do_op(SLT,  XLEN'(2), ONES, 0, 1'b0, 1'b0);
    do_op(MUL,  XLEN'(-2), XLEN'(3), 0, 1'b0, 1'b0);
    do_op(MULH, XLEN'(-2), XLEN'(3), 0, 1'b0, 1'b0);
    do_op(DIV,  XLEN'(-7), XLEN'(2), 0, 1'b0, 1'b0);
    do_op(REM,  XLEN'(-7), XLEN'(2), 0, 1'b0, 1'b0);
    do_op(DIVU, XLEN'(100), XLEN'(7), 0, 1'b0, 1'b0);
    do_op(REMU, XLEN'(100), XLEN'(7), 0, 1'b0, 1'b0);
    do_op(DIVU, XLEN'(5), '0, 0, 1'b0, 1'b0);
    do_op(REM,  MIN_V, ONES, 0, 1'b0, 1'b0);
    do_op(DIV,  MIN_V, ONES, 0, 1'b0, 1'b0);
    do_op(MUL,  XLEN'(-2), XLEN'(3), 5, 1'b0, 1'b1);
    do_op(MULH, MIN_V, MIN_V, 2, 1'b0, 1'b1);

    reset_mid_op();

    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
